// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel state encoding and mode values.
package timer_bank_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: down-counter clocked by the shared strobe, with tick pulse and square-wave output.
module timer_chan
    import timer_bank_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stb,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [Width-1:0] kmax,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    chan_state_t      state;
    logic [Width-1:0] cnt;
    logic             mode_q;

    // busy mirrors the registered state, so it is itself a registered output
    assign busy = (state == ST_RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= MODE_ONESHOT;
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
            end else if (start) begin
                cnt    <= kmax;
                mode_q <= mode;
                state  <= ST_RUN;
            end else if (state == ST_RUN && stb) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    tick <= 1'b1;
                    sq   <= ~sq;
                    // reload from the live kmax so a new period applies from the next cycle on
                    if (mode_q == MODE_PERIODIC) cnt <= kmax;
                    else                         state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel down-count timer bank sharing one prescaler strobe across all channels.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int N     = 2,
    parameter int Width = 8,
    parameter int PreW  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [PreW-1:0]    pre_i,
    input  logic [N-1:0]       start_i,
    input  logic [N-1:0]       stop_i,
    input  logic [N-1:0]       mode_i,
    input  logic [N*Width-1:0] kmax_i,
    output logic [N-1:0]       tick_o,
    output logic [N-1:0]       sq_o,
    output logic [N-1:0]       busy_o
);

    logic [PreW-1:0] pre_cnt;
    logic            stb;

    assign stb = en_i && (pre_cnt == '0);

    // pre_i is only sampled at reload, so a new divisor starts with the next prescaler period
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
        end else if (en_i) begin
            if (stb) pre_cnt <= pre_i;
            else     pre_cnt <= pre_cnt - 1'b1;
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_chan
        timer_chan #(
            .Width(Width)
        ) u_chan (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .stb   (stb),
            .start (start_i[c]),
            .stop  (stop_i[c]),
            .mode  (mode_i[c]),
            .kmax  (kmax_i[c*Width +: Width]),
            .tick  (tick_o[c]),
            .sq    (sq_o[c]),
            .busy  (busy_o[c])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random traffic against a strobe-counting model.
module tb_timer_bank;

    localparam int N = 2;
    localparam int W = 8;
    localparam int P = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           en_i;
    logic [P-1:0]   pre_i;
    logic [N-1:0]   start_i;
    logic [N-1:0]   stop_i;
    logic [N-1:0]   mode_i;
    logic [N*W-1:0] kmax_i;
    logic [N-1:0]   tick_o;
    logic [N-1:0]   sq_o;
    logic [N-1:0]   busy_o;

    timer_bank #(.N(N), .Width(W), .PreW(P)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .pre_i   (pre_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .mode_i  (mode_i),
        .kmax_i  (kmax_i),
        .tick_o  (tick_o),
        .sq_o    (sq_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: strobes occur every pre+1 enabled cycles; a channel ticks after kmax+1 strobes since its load.
    int  en_idx;
    int  next_stb;
    bit  run_m  [N];
    bit  mode_m [N];
    bit  sq_m   [N];
    bit  tick_m [N];
    int  seen_m [N];
    int  len_m  [N];

    int total = 0;
    int bad   = 0;
    logic [3*N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        en_idx   = 0;
        next_stb = 0;
        for (int c = 0; c < N; c++) begin
            run_m[c] = 0; mode_m[c] = 0; sq_m[c] = 0; tick_m[c] = 0;
            seen_m[c] = 0; len_m[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit stb;
        logic [N-1:0] tv, sv, bv;
        stb = en_i && (en_idx == next_stb);
        if (en_i) begin
            if (stb) next_stb = en_idx + int'(pre_i) + 1;
            en_idx++;
        end
        for (int c = 0; c < N; c++) begin
            tick_m[c] = 0;
            if (stop_i[c]) begin
                run_m[c] = 0;
            end else if (start_i[c]) begin
                run_m[c] = 1; mode_m[c] = mode_i[c]; seen_m[c] = 0;
                len_m[c] = int'(kmax_i[c*W +: W]);
            end else if (run_m[c] && stb) begin
                seen_m[c]++;
                if (seen_m[c] == len_m[c] + 1) begin
                    tick_m[c] = 1;
                    sq_m[c]   = !sq_m[c];
                    if (mode_m[c]) begin
                        seen_m[c] = 0;
                        len_m[c]  = int'(kmax_i[c*W +: W]);
                    end else begin
                        run_m[c] = 0;
                    end
                end
            end
            tv[c] = tick_m[c]; sv[c] = sq_m[c]; bv[c] = run_m[c];
        end
        exp_q.push_back({bv, sv, tv});
    endtask

    // One clock: predict, advance, sample 1 time unit after the edge, compare.
    task automatic step();
        logic [3*N-1:0] e;
        model_edge();
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check("tick", 32'(tick_o), 32'(e[N-1:0]));
        check("sq",   32'(sq_o),   32'(e[2*N-1:N]));
        check("busy", 32'(busy_o), 32'(e[3*N-1:2*N]));
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = '0; stop_i = '0;
        @(posedge clk_i);
        #1;
        check("rst_out", 32'({tick_o, sq_o, busy_o}), 32'd0);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic set_kmax(input int c, input int v);
        kmax_i[c*W +: W] = W'(v);
    endtask

    task automatic pulse_start(input int c, input bit m);
        start_i[c] = 1'b1; mode_i[c] = m;
        step();
        start_i[c] = 1'b0;
    endtask

    // Edges from the current point until the channel ticks, bounded.
    task automatic wait_tick(input int c, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_o[c] && n < 300);
        if (n >= 300) check("tick_timeout", 32'(n), 32'd0);
    endtask

    int n;
    logic [N-1:0] sq_hold;

    initial begin
        rst_i = 1'b1; en_i = 1'b0; pre_i = '0; start_i = '0; stop_i = '0;
        mode_i = '0; kmax_i = '0;
        model_reset();
        #3;
        check("rst_async_init", 32'({tick_o, sq_o, busy_o}), 32'd0);

        // one-shot latency
        do_reset();
        en_i = 1'b1; pre_i = 0; set_kmax(0, 3);
        pulse_start(0, 1'b0);
        wait_tick(0, n);
        check("oneshot_latency", 32'(n), 32'd4);
        check("oneshot_busy", 32'(busy_o[0]), 32'd0);
        check("oneshot_sq", 32'(sq_o[0]), 32'd1);
        step();
        check("oneshot_tick_width", 32'(tick_o[0]), 32'd0);

        // periodic with prescaler, other channel idle
        do_reset();
        pre_i = 1; set_kmax(1, 4);
        pulse_start(1, 1'b1);
        wait_tick(1, n);
        sq_hold = sq_o;
        wait_tick(1, n);
        check("periodic_interval", 32'(n), 32'd10);
        check("periodic_sq_toggle", 32'(sq_o[1]), 32'(!sq_hold[1]));
        wait_tick(1, n);
        check("periodic_interval2", 32'(n), 32'd10);
        check("periodic_sq_period", 32'(sq_o[1]), 32'(sq_hold[1]));
        check("ch0_idle", 32'({tick_o[0], sq_o[0], busy_o[0]}), 32'd0);

        // stop colliding with terminal count, then start+stop together
        do_reset();
        pre_i = 0; set_kmax(0, 2);
        pulse_start(0, 1'b1);
        step(); step();
        stop_i[0] = 1'b1;
        step();
        stop_i[0] = 1'b0;
        check("collide_tick", 32'(tick_o[0]), 32'd0);
        check("collide_busy", 32'(busy_o[0]), 32'd0);
        check("collide_sq", 32'(sq_o[0]), 32'd0);
        start_i[0] = 1'b1; stop_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0; stop_i[0] = 1'b0;
        check("start_stop_busy", 32'(busy_o[0]), 32'd0);

        // kmax=0: tick every cycle; en low freezes everything
        set_kmax(0, 0);
        pulse_start(0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("k0_tick", 32'(tick_o[0]), 32'd1);
        sq_hold = sq_o;
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("k0_frozen_sq", 32'(sq_o[0]), 32'(sq_hold[0]));
        check("k0_frozen_tick", 32'(tick_o[0]), 32'd0);
        en_i = 1'b1;
        step();
        check("k0_resume_tick", 32'(tick_o[0]), 32'd1);

        // on-the-fly period change and immediate restart
        do_reset();
        set_kmax(0, 5);
        pulse_start(0, 1'b1);
        wait_tick(0, n);
        check("fly_first", 32'(n), 32'd6);
        step(); step();
        set_kmax(0, 2);
        wait_tick(0, n);
        check("fly_current", 32'(n + 2), 32'd6);
        wait_tick(0, n);
        check("fly_new", 32'(n), 32'd3);
        step();
        pulse_start(0, 1'b1);
        wait_tick(0, n);
        check("fly_restart", 32'(n), 32'd3);

        // asynchronous reset between edges, then clean restart
        set_kmax(0, 3);
        pulse_start(0, 1'b0);
        step();
        #2 rst_i = 1'b1;
        #1;
        check("async_rst", 32'({tick_o, sq_o, busy_o}), 32'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        model_reset();
        pulse_start(0, 1'b0);
        wait_tick(0, n);
        check("post_rst_latency", 32'(n), 32'd4);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) pre_i = P'($urandom_range(0, 3));
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 9) == 0) set_kmax(c, $urandom_range(0, 6));
                start_i[c] = ($urandom_range(0, 14) == 0);
                stop_i[c]  = ($urandom_range(0, 39) == 0);
                mode_i[c]  = 1'($urandom_range(0, 1));
            end
            step();
        end
        start_i = '0; stop_i = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
